// File: rtl/framebuffer_scan_reader_pkg.sv
// SRAM request/result types shared by the framebuffer writer and the scan reader.
package framebuffer_scan_reader_pkg;

  typedef logic [19:0] SramAddress_t;
  typedef logic [15:0] SramData_t;

  typedef struct packed {
    SramAddress_t address;
    SramData_t    dout;
    logic         den;
    logic         oe_n;
    logic         we_n;
  } SramRequest_t;

  typedef struct packed {
    logic      done;
    SramData_t din;
  } SramResult_t;

endpackage

// File: rtl/framebuffer_scan_reader.sv
// Raster-order read-back of the SRAM framebuffer into a show-ahead pixel FIFO.
// At most one SRAM read is in flight, and a read is started only when the FIFO has a slot for it.
module framebuffer_scan_reader
  import framebuffer_scan_reader_pkg::*;
#(
  parameter int FB_WIDTH   = 640,
  parameter int FB_HEIGHT  = 480,
  parameter int FIFO_DEPTH = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         frameStart,
  input  SramAddress_t baseAddress,
  input  SramResult_t  ramResult,
  output SramRequest_t ramRequest,
  output logic         pixelValid,
  output SramData_t    pixelData,
  input  logic         pixelReady,
  output logic         frameDone,
  output logic         underflow
);

  localparam int NPIX  = FB_WIDTH * FB_HEIGHT;
  localparam int IDX_W = $clog2(NPIX + 1);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NPIX - 1);
  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    STORE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  SramAddress_t     r_base;
  SramAddress_t     r_base_pend;
  logic [IDX_W-1:0] r_index;
  logic             r_restart;
  SramData_t        r_pixel;
  SramData_t        r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             r_underflow;
  logic             r_frame_done;

  logic w_den;
  logic w_defer;
  logic w_start;
  logic w_resume;
  logic w_capture;
  logic w_push;
  logic w_pop;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // While a restart is pending, den stays up because the flushed FIFO keeps r_count below depth.
  always_comb begin
    w_state_next = r_state;
    w_den        = 1'b0;
    case (r_state)
      IDLE: begin
        w_state_next = frameStart ? ISSUE : IDLE;
      end
      ISSUE: begin
        w_den = (r_count < DEPTH_C);
        if (w_den && ramResult.done && !r_restart && !frameStart) begin
          w_state_next = STORE;
        end else begin
          w_state_next = ISSUE;
        end
      end
      STORE: begin
        if (frameStart) begin
          w_state_next = ISSUE;
        end else if (r_index == LAST_IDX) begin
          w_state_next = DONE;
        end else begin
          w_state_next = ISSUE;
        end
      end
      DONE: begin
        w_state_next = frameStart ? ISSUE : DONE;
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  assign w_defer   = frameStart && w_den && !ramResult.done;
  assign w_start   = frameStart && !w_defer;
  assign w_resume  = r_restart && w_den && ramResult.done && !frameStart;
  assign w_capture = w_den && ramResult.done && !r_restart && !frameStart;
  assign w_push    = (r_state == STORE) && !frameStart;
  assign w_pop     = pixelValid && pixelReady && !frameStart;

  // New base is parked in r_base_pend so the address stays stable until the held read completes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_base      <= '0;
      r_base_pend <= '0;
      r_index     <= '0;
      r_restart   <= 1'b0;
      r_pixel     <= '0;
    end else begin
      if (w_start) begin
        r_base    <= baseAddress;
        r_index   <= '0;
        r_restart <= 1'b0;
      end else if (w_defer) begin
        r_base_pend <= baseAddress;
        r_restart   <= 1'b1;
      end else if (w_resume) begin
        r_base    <= r_base_pend;
        r_index   <= '0;
        r_restart <= 1'b0;
      end else if (w_push && (r_index != LAST_IDX)) begin
        r_index <= r_index + IDX_W'(1);
      end
      if (w_capture) begin
        r_pixel <= ramResult.din;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= r_pixel;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (frameStart) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_underflow  <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= (w_state_next == DONE);
      if (frameStart) begin
        r_underflow <= 1'b0;
      end else if (pixelReady && !pixelValid) begin
        r_underflow <= 1'b1;
      end
    end
  end

  always_comb begin
    ramRequest         = '0;
    ramRequest.address = r_base + SramAddress_t'(r_index);
    ramRequest.dout    = '0;
    ramRequest.den     = w_den;
    ramRequest.oe_n    = ~w_den;
    ramRequest.we_n    = 1'b1;
  end

  assign pixelValid = (r_count != '0);
  assign pixelData  = pixelValid ? r_mem[r_rd_ptr] : '0;
  assign frameDone  = r_frame_done;
  assign underflow  = r_underflow;

endmodule
